sequence_checker: RTL and testbench
===================================

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 16: maximum sequence length (2..16).
REQ-002 SHALL have parameter SHOW_CYCLES, default 25000000: cycles each stored symbol is displayed (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 12500000: blank cycles after each displayed symbol (>=1).
REQ-004 SHALL have port seq_clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port seq_reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1: level, sampled each cycle; begins a new game.
REQ-007 SHALL have port rand_in, input, 3: free-running symbol from the random generator, nominally 0..4.
REQ-008 SHALL have port key_valid, input, 1: one-cycle strobe, player entry present.
REQ-009 SHALL have port key_in, input, 3: player symbol, valid with key_valid.
REQ-010 SHALL have port show_valid, output, 1: a stored symbol is being displayed.
REQ-011 SHALL have port show_value, output, 3: displayed symbol; 0 when show_valid=0.
REQ-012 SHALL have port await_key, output, 1: high only in INPUT.
REQ-013 SHALL have port round_pass, output, 1: one-cycle pulse on a correctly completed round.
REQ-014 SHALL have port fail, output, 1: sticky, wrong entry made.
REQ-015 SHALL have port complete, output, 1: sticky, DEPTH rounds passed.
REQ-016 SHALL have port level, output, 5: current stored sequence length.

Function
REQ-017 SHALL implement states IDLE, APPEND, SHOW, GAP, INPUT, PASS, FAIL.
REQ-018 SHALL, in IDLE or FAIL with start=1 at an edge: clear level, fail and complete, then enter APPEND next cycle; start SHALL be ignored in every other state.
REQ-019 SHALL, in APPEND (exactly one cycle): write mem[level] <= rand_in if rand_in<=4, else rand_in-5 (5,6,7 -> 0,1,2); increment level; clear index; enter SHOW.
REQ-020 SHALL, in SHOW: drive show_valid=1 and show_value=mem[index] for exactly SHOW_CYCLES cycles, then enter GAP.
REQ-021 SHALL, in GAP: drive show_valid=0 for exactly GAP_CYCLES cycles; then, if index==level-1, clear index and enter INPUT, else increment index and re-enter SHOW.
REQ-022 SHALL, in INPUT with key_valid=1: on key_in!=mem[index], enter FAIL; on a match with index==level-1, enter PASS; on a match otherwise, increment index.
REQ-023 SHALL treat key_in values 5..7 as a mismatch.
REQ-024 SHALL ignore key_valid in all states except INPUT.
REQ-025 SHALL, in PASS (exactly one cycle): assert round_pass; if level<DEPTH, enter APPEND; else set complete and enter IDLE.
REQ-026 SHALL, in FAIL: hold fail=1 and all other outputs inactive, with level frozen, until start.
REQ-027 SHALL use one down-counter shared by SHOW and GAP, reloaded on every state entry.
REQ-028 SHALL keep mem contents unchanged except by APPEND; entries at index>=level are don't-care.

Reset
REQ-029 SHALL, while seq_reset=1, immediately force: state IDLE, level 0, index 0, counter 0, show_valid 0, show_value 0, await_key 0, round_pass 0, fail 0, complete 0; mem need not be cleared.
REQ-030 SHALL, on seq_reset assertion in any state (mid-show, mid-input), abandon the game with no further output pulses.
REQ-031 SHALL leave IDLE only on start after seq_reset deasserts.

Verification (SHOW_CYCLES=2, GAP_CYCLES=1, DEPTH=4)
REQ-032 SHALL cover: start, rand_in=3 -> one cycle APPEND, then show_valid=1/show_value=3 for 2 cycles, 1 blank cycle, then await_key=1, level=1.
REQ-033 SHALL cover: rand_in=6 during APPEND -> stored and shown as 1.
REQ-034 SHALL cover: round 2 with stored {3,0}, keys 3 then 0 -> round_pass for one cycle, then APPEND, level=3.
REQ-035 SHALL cover: level=2, stored {3,0}, keys 3 then 2 -> fail=1 sticky, await_key=0; key_valid afterwards is ignored; start then gives level 1 and fail=0.
REQ-036 SHALL cover: four correct rounds -> complete=1, state IDLE, level=4; key_valid in IDLE causes no change.
REQ-037 SHALL cover: seq_reset pulse mid-SHOW -> outputs zero in the same cycle, no round_pass/fail; start afterwards -> level=1.

Source files
------------

// File: rtl/sequence_checker.sv
// sequence_checker: memory-game sequencer. Each round appends one symbol
// (0..4) taken from rand_in, replays the whole stored sequence (each symbol
// shown for SHOW_CYCLES cycles followed by GAP_CYCLES blank cycles), then
// waits for the player to key the sequence back. A correct round pulses
// round_pass; a wrong key makes fail sticky; DEPTH passed rounds set complete.
//
// Ports:
//   seq_clock   - clock, all state updates on rising edge
//   seq_reset   - asynchronous active-high reset
//   start       - level, begins a new game from IDLE or FAIL
//   rand_in     - free-running random symbol, 5..7 folded to 0..2
//   key_valid   - one-cycle strobe with player entry key_in
//   key_in      - player symbol (5..7 always mismatch)
//   show_valid  - a stored symbol is being displayed
//   show_value  - displayed symbol, 0 when not displaying
//   await_key   - waiting for player entry
//   round_pass  - one-cycle pulse on a completed round
//   fail        - sticky wrong-entry flag
//   complete    - sticky, DEPTH rounds passed
//   level       - current stored sequence length
module sequence_checker #(
  parameter int DEPTH       = 16,
  parameter int SHOW_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000
) (
  input  logic       seq_clock,
  input  logic       seq_reset,
  input  logic       start,
  input  logic [2:0] rand_in,
  input  logic       key_valid,
  input  logic [2:0] key_in,
  output logic       show_valid,
  output logic [2:0] show_value,
  output logic       await_key,
  output logic       round_pass,
  output logic       fail,
  output logic       complete,
  output logic [4:0] level
);

  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SHOW_LOAD = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [4:0]    DEPTH_L   = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPEND = 3'd1,
    S_SHOW   = 3'd2,
    S_GAP    = 3'd3,
    S_INPUT  = 3'd4,
    S_PASS   = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      mem [DEPTH];
  logic [IW-1:0]   index, index_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [4:0]      level_nx;
  logic            complete_nx;
  logic            mem_we;
  logic [2:0]      sym;
  logic [2:0]      cur;
  logic            last;
  logic [2:0]      show_value_nx;

  // Fold out-of-range random symbols onto 0..2.
  assign sym  = (rand_in <= 3'd4) ? rand_in : (rand_in - 3'd5);
  assign cur  = mem[index];
  assign last = ({{(5-IW){1'b0}}, index} == (level - 5'd1));

  // Next-state, datapath and counter control.
  always_comb begin
    state_nx    = state;
    level_nx    = level;
    index_nx    = index;
    cnt_nx      = cnt;
    complete_nx = complete;
    mem_we      = 1'b0;
    case (state)
      S_IDLE, S_FAIL: begin
        if (start) begin
          level_nx    = 5'd0;
          complete_nx = 1'b0;
          index_nx    = '0;
          cnt_nx      = '0;
          state_nx    = S_APPEND;
        end else begin
          state_nx = state;
        end
      end
      S_APPEND: begin
        mem_we   = 1'b1;
        level_nx = level + 5'd1;
        index_nx = '0;
        cnt_nx   = SHOW_LOAD;
        state_nx = S_SHOW;
      end
      S_SHOW: begin
        if (cnt == '0) begin
          cnt_nx   = GAP_LOAD;
          state_nx = S_GAP;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          if (last) begin
            index_nx = '0;
            cnt_nx   = '0;
            state_nx = S_INPUT;
          end else begin
            index_nx = index + IW'(1);
            cnt_nx   = SHOW_LOAD;
            state_nx = S_SHOW;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_INPUT: begin
        if (key_valid) begin
          // Stored symbols are always 0..4, so keys 5..7 can never match.
          if ((key_in > 3'd4) || (key_in != cur)) begin
            cnt_nx   = '0;
            state_nx = S_FAIL;
          end else if (last) begin
            cnt_nx   = '0;
            state_nx = S_PASS;
          end else begin
            index_nx = index + IW'(1);
          end
        end else begin
          state_nx = S_INPUT;
        end
      end
      S_PASS: begin
        cnt_nx = '0;
        if (level < DEPTH_L) begin
          state_nx = S_APPEND;
        end else begin
          complete_nx = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe; the symbol being appended this edge is bypassed.
  always_comb begin
    show_value_nx = 3'd0;
    if (state_nx == S_SHOW) begin
      if (mem_we && (index_nx == level[IW-1:0])) begin
        show_value_nx = sym;
      end else begin
        show_value_nx = mem[index_nx];
      end
    end else begin
      show_value_nx = 3'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge seq_clock or posedge seq_reset) begin
    if (seq_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge seq_clock or posedge seq_reset) begin
    if (seq_reset) begin
      level      <= 5'd0;
      index      <= '0;
      cnt        <= '0;
      complete   <= 1'b0;
      show_valid <= 1'b0;
      show_value <= 3'd0;
      await_key  <= 1'b0;
      round_pass <= 1'b0;
      fail       <= 1'b0;
    end else begin
      level      <= level_nx;
      index      <= index_nx;
      cnt        <= cnt_nx;
      complete   <= complete_nx;
      show_valid <= (state_nx == S_SHOW);
      show_value <= show_value_nx;
      await_key  <= (state_nx == S_INPUT);
      round_pass <= (state_nx == S_PASS);
      fail       <= (state_nx == S_FAIL);
    end
  end

  // Sequence storage, written only while appending.
  always_ff @(posedge seq_clock) begin
    if (mem_we) begin
      mem[level[IW-1:0]] <= sym;
    end
  end

endmodule

// File: tb/tb_sequence_checker.sv
module tb_sequence_checker;

  logic       seq_clock = 1'b0;
  logic       seq_reset;
  logic       start;
  logic [2:0] rand_in;
  logic       key_valid;
  logic [2:0] key_in;
  logic       show_valid;
  logic [2:0] show_value;
  logic       await_key;
  logic       round_pass;
  logic       fail;
  logic       complete;
  logic [4:0] level;

  sequence_checker #(.DEPTH(4), .SHOW_CYCLES(2), .GAP_CYCLES(1)) dut (
    .seq_clock (seq_clock),
    .seq_reset (seq_reset),
    .start     (start),
    .rand_in   (rand_in),
    .key_valid (key_valid),
    .key_in    (key_in),
    .show_valid(show_valid),
    .show_value(show_value),
    .await_key (await_key),
    .round_pass(round_pass),
    .fail      (fail),
    .complete  (complete),
    .level     (level)
  );

  always #5 seq_clock = ~seq_clock;

  typedef struct {
    string       tag;
    logic [12:0] val;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] m_mem [4];
  int         m_level = 0;
  logic       m_complete = 1'b0;

  function automatic logic [2:0] fold(input logic [2:0] r);
    return (r <= 3'd4) ? r : (r - 3'd5);
  endfunction

  // Expected bundle {show_valid, show_value, await_key, round_pass, fail, complete, level}
  function automatic logic [12:0] ex(input logic sv, input logic [2:0] v, input logic ak,
                                     input logic rp, input logic f);
    return {sv, v, ak, rp, f, m_complete, 5'(m_level)};
  endfunction

  task automatic check_pop();
    exp_t        e;
    logic [12:0] obs;
    obs = {show_valid, show_value, await_key, round_pass, fail, complete, level};
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic [2:0] r,
                      input logic kv, input logic [2:0] k, input logic [12:0] e);
    start = st; rand_in = r; key_valid = kv; key_in = k;
    sb.push_back('{tag, e});
    @(posedge seq_clock); #1;
    check_pop();
  endtask

  task automatic check_now(input string tag, input logic [12:0] e);
    sb.push_back('{tag, e});
    check_pop();
  endtask

  task automatic new_game();
    m_level = 0; m_complete = 1'b0;
    step("start", 1'b1, 3'd0, 1'b0, 3'd0, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
  endtask

  // Append one symbol and follow the full replay; noise drives start and
  // key_valid during the replay, both of which must be ignored.
  task automatic append_show(input logic [2:0] r, input logic noise);
    m_mem[m_level] = fold(r);
    m_level++;
    step("append", 1'b0, r, 1'b0, 3'd0, ex(1'b1, m_mem[0], 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < m_level; i++) begin
      step("show_hold", noise, 3'd7, noise, 3'd0, ex(1'b1, m_mem[i], 1'b0, 1'b0, 1'b0));
      step("gap", noise, 3'd1, noise, 3'd0, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
      if (i < m_level - 1)
        step("show_next", noise, 3'd2, noise, 3'd0, ex(1'b1, m_mem[i+1], 1'b0, 1'b0, 1'b0));
      else
        step("to_input", 1'b0, 3'd2, 1'b0, 3'd0, ex(1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic play_round();
    step("key_wait", 1'b0, 3'd0, 1'b0, 3'd0, ex(1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < m_level; i++) begin
      if (i < m_level - 1)
        step("key_ok", 1'b0, 3'd0, 1'b1, m_mem[i], ex(1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
      else
        step("key_last", 1'b0, 3'd0, 1'b1, m_mem[i], ex(1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    end
    if (m_level < 4) begin
      step("to_append", 1'b0, 3'd0, 1'b0, 3'd0, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    end else begin
      m_complete = 1'b1;
      step("to_idle", 1'b0, 3'd0, 1'b0, 3'd0, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    seq_reset = 1'b1; start = 1'b0; rand_in = 3'd0; key_valid = 1'b0; key_in = 3'd0;
    @(posedge seq_clock); #1;
    check_now("reset_state", ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    step("start_in_reset", 1'b1, 3'd3, 1'b1, 3'd3, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    seq_reset = 1'b0;
    step("idle_hold", 1'b0, 3'd3, 1'b1, 3'd3, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));

    // Game 1: four correct rounds, symbols 3, 5->0, 6->1, 7->2
    new_game();
    append_show(3'd3, 1'b0);
    play_round();
    append_show(3'd5, 1'b1);
    play_round();
    append_show(3'd6, 1'b0);
    play_round();
    append_show(3'd7, 1'b0);
    play_round();
    step("idle_key_ignored", 1'b0, 3'd0, 1'b1, 3'd3, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));

    // Game 2: wrong second key in round 2
    new_game();
    append_show(3'd3, 1'b0);
    play_round();
    append_show(3'd0, 1'b0);
    step("key_ok", 1'b0, 3'd0, 1'b1, 3'd3, ex(1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
    step("key_wrong", 1'b0, 3'd0, 1'b1, 3'd2, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    step("fail_key_ignored", 1'b0, 3'd0, 1'b1, 3'd0, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    step("fail_sticky", 1'b0, 3'd0, 1'b0, 3'd0, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    new_game();
    append_show(3'd4, 1'b0);
    step("key_out_of_range", 1'b0, 3'd0, 1'b1, 3'd7, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b1));

    // Game 3: reset in the middle of the replay
    new_game();
    m_mem[0] = 3'd2; m_level = 1;
    step("append", 1'b0, 3'd2, 1'b0, 3'd0, ex(1'b1, 3'd2, 1'b0, 1'b0, 1'b0));
    #2 seq_reset = 1'b1;
    #1;
    m_level = 0;
    check_now("reset_mid_show", ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    @(posedge seq_clock); #1;
    seq_reset = 1'b0;
    step("post_reset_idle", 1'b0, 3'd0, 1'b0, 3'd0, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    step("post_reset_idle2", 1'b0, 3'd0, 1'b1, 3'd2, ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    new_game();
    append_show(3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
